// File: rtl/vga_timing_if.sv
// Pixel-pipeline side of the VGA timing controller: pixel-step enable in, sync/DE/coords/strobes out.
interface vga_timing_if;
  logic        pix_en;
  logic        hsync;
  logic        vsync;
  logic        de;
  logic [10:0] x;
  logic [10:0] y;
  logic        line_end;
  logic        frame_start;

  modport master (
    input  pix_en,
    output hsync, vsync, de, x, y, line_end, frame_start
  );

  modport slave (
    output pix_en,
    input  hsync, vsync, de, x, y, line_end, frame_start
  );
endinterface

// File: rtl/vga_timing_ctrl.sv
// VGA timing sequencer: horizontal/vertical counters with ACTIVE/FRONT/SYNC/BACK phase machines.
// Outputs are registered and describe the pixel counted on the previous pix_en step.
module vga_timing_ctrl #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          H_POL    = 1'b0,
  parameter bit          V_POL    = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  vga_timing_if.master     bus
);

  localparam int unsigned HTotal = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Last count of each phase; a phase ends when the count equals its constant.
  localparam logic [10:0] HActEnd  = 11'(H_ACTIVE - 1);
  localparam logic [10:0] HFpEnd   = 11'(H_ACTIVE + H_FP - 1);
  localparam logic [10:0] HSyncEnd = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [10:0] HTotEnd  = 11'(HTotal - 1);
  localparam logic [10:0] VActEnd  = 11'(V_ACTIVE - 1);
  localparam logic [10:0] VFpEnd   = 11'(V_ACTIVE + V_FP - 1);
  localparam logic [10:0] VSyncEnd = 11'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [10:0] VTotEnd  = 11'(VTotal - 1);

  typedef enum logic [1:0] {PhActive, PhFront, PhSync, PhBack} phase_e;

  logic [10:0] h_cnt, v_cnt;
  logic [10:0] h_cnt_d, v_cnt_d;
  phase_e      h_ph, v_ph;
  phase_e      h_ph_d, v_ph_d;
  logic        h_last, v_last;

  logic        hsync_q, vsync_q, de_q;
  logic [10:0] x_q, y_q;
  logic        line_end_q, frame_start_q;

  always_comb begin
    h_last  = (h_cnt == HTotEnd);
    v_last  = (v_cnt == VTotEnd);
    h_cnt_d = h_last ? 11'd0 : h_cnt + 11'd1;
    v_cnt_d = v_last ? 11'd0 : v_cnt + 11'd1;

    h_ph_d = h_ph;
    unique case (h_ph)
      PhActive: if (h_cnt == HActEnd)  h_ph_d = PhFront;
      PhFront:  if (h_cnt == HFpEnd)   h_ph_d = PhSync;
      PhSync:   if (h_cnt == HSyncEnd) h_ph_d = PhBack;
      PhBack:   if (h_cnt == HTotEnd)  h_ph_d = PhActive;
      default:                         h_ph_d = PhActive;
    endcase

    v_ph_d = v_ph;
    unique case (v_ph)
      PhActive: if (v_cnt == VActEnd)  v_ph_d = PhFront;
      PhFront:  if (v_cnt == VFpEnd)   v_ph_d = PhSync;
      PhSync:   if (v_cnt == VSyncEnd) v_ph_d = PhBack;
      PhBack:   if (v_cnt == VTotEnd)  v_ph_d = PhActive;
      default:                         v_ph_d = PhActive;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_cnt         <= 11'd0;
      v_cnt         <= 11'd0;
      h_ph          <= PhActive;
      v_ph          <= PhActive;
      hsync_q       <= ~H_POL;
      vsync_q       <= ~V_POL;
      de_q          <= 1'b0;
      x_q           <= 11'd0;
      y_q           <= 11'd0;
      line_end_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      line_end_q    <= 1'b0;
      frame_start_q <= 1'b0;
      if (bus.pix_en) begin
        // Outputs sample the pre-advance state, giving one step of latency.
        hsync_q       <= (h_ph == PhSync) ? H_POL : ~H_POL;
        vsync_q       <= (v_ph == PhSync) ? V_POL : ~V_POL;
        de_q          <= (h_ph == PhActive) && (v_ph == PhActive);
        x_q           <= h_cnt;
        y_q           <= v_cnt;
        line_end_q    <= h_last;
        frame_start_q <= (h_cnt == 11'd0) && (v_cnt == 11'd0);
        h_cnt         <= h_cnt_d;
        h_ph          <= h_ph_d;
        if (h_last) begin
          v_cnt <= v_cnt_d;
          v_ph  <= v_ph_d;
        end
      end
    end
  end

  assign bus.hsync       = hsync_q;
  assign bus.vsync       = vsync_q;
  assign bus.de          = de_q;
  assign bus.x           = x_q;
  assign bus.y           = y_q;
  assign bus.line_end    = line_end_q;
  assign bus.frame_start = frame_start_q;

endmodule

// File: doc/vga_timing_ctrl.md
Name: vga_timing_ctrl

Overview:
- Sequences the 11-bit horizontal and vertical pixel counters of the VGA driver.
- Each counter runs through an ACTIVE/FRONT/SYNC/BACK phase machine, and each phase boundary is an equality compare of the count against a parameter constant.
- Produces hsync, vsync, data-enable, pixel coordinates and frame/line strobes for the pixel pipeline.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- H_POL, 0, hsync level during SYNC phase (0 = active-low)
- V_POL, 0, vsync level during SYNC phase (0 = active-low)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  synchronous active-low reset
- pix_en  input  1  pixel-clock enable; one pixel step per clk with pix_en=1
- hsync  output  1  horizontal sync
- vsync  output  1  vertical sync
- de  output  1  data enable, 1 when the pixel is in the H_ACTIVE and V_ACTIVE regions
- x  output  11  pixel column, valid when de=1
- y  output  11  pixel row, valid when de=1
- line_end  output  1  one-clk pulse: last pixel of a line processed
- frame_start  output  1  one-clk pulse: pixel (0,0) processed

Behaviour:
- Single clock domain; reset is synchronous and active-low.
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Constraints: each total ≤ 2048; every phase parameter ≥ 1.
- Internal state:
  - h_cnt, v_cnt: 11 bits each, unsigned.
  - h_ph, v_ph: 2-bit phase, one of ACTIVE, FRONT, SYNC, BACK.
- Horizontal phase transitions, on pix_en=1 only:
  - ACTIVE→FRONT at h_cnt==H_ACTIVE-1
  - FRONT→SYNC at h_cnt==H_ACTIVE+H_FP-1
  - SYNC→BACK at h_cnt==H_ACTIVE+H_FP+H_SYNC-1
  - BACK→ACTIVE at h_cnt==H_TOTAL-1
- Vertical phase: same structure using v_cnt and V_* parameters. v_cnt and v_ph advance only on a pix_en cycle where h_cnt==H_TOTAL-1.
- Counter wrap:
  - h_cnt wraps from H_TOTAL-1 to 0.
  - v_cnt wraps from V_TOTAL-1 to 0 in the same cycle h_cnt wraps.
  - No other wrap is permitted; counters never exceed TOTAL-1.
- Output timing (registered, 1-step latency):
  - On each clk with pix_en=1, outputs are loaded from the pre-advance state.
  - hsync = (h_ph==SYNC) ? H_POL : ~H_POL
  - vsync = (v_ph==SYNC) ? V_POL : ~V_POL
  - de = (h_ph==ACTIVE && v_ph==ACTIVE)
  - x = h_cnt, y = v_cnt
  - Result: outputs in cycle N+1 describe the pixel counted in cycle N.
- Strobes:
  - line_end = 1 for exactly one clk after a pix_en cycle with h_cnt==H_TOTAL-1.
  - frame_start = 1 for exactly one clk after a pix_en cycle with h_cnt==0 and v_cnt==0.
  - Both are 0 on every other clk, including clks with pix_en=0.
- pix_en=0: counters, phases, hsync, vsync, de, x and y hold their values; strobes go to 0.
- Reset (rst_n=0 at a clk edge):
  - h_cnt=0, v_cnt=0, h_ph=v_ph=ACTIVE
  - hsync=~H_POL, vsync=~V_POL, de=0, x=0, y=0, line_end=0, frame_start=0
  - Reset overrides pix_en.
  - Mid-frame reset restarts timing at (0,0) with no partial sync pulse extension.
- First pix_en cycle after reset outputs pixel (0,0): de=1, frame_start=1.
- Simultaneous h and v wrap (last pixel of frame):
  - line_end pulses.
  - Next pix_en cycle yields frame_start.

Test Plan:
- Reset, then pix_en=1 continuously (default parameters) → 1 clk after first pix_en: de=1, x=0, y=0, frame_start=1; frame_start recurs every 420000 clks.
- Line 0 timing, pix_en=1 continuously → de=1 for x=0..639; hsync=0 exactly for pixels 656..751 (96 clks); line_end pulses after pixel 799; y increments to 1 on the next pixel.
- Vertical timing → vsync=0 exactly on lines 490..491 (1600 clks); de=0 on all lines 480..524; y wraps from 524 to 0.
- pix_en toggled 1,0,0,1 with a random ~30% duty across a full frame → x/y/hsync/vsync/de sequence identical to the continuous run with pix_en=0 cycles removed; strobes never high on pix_en=0+1 cycles.
- rst_n=0 for one clk at pixel (700,300), during hsync → next clk: hsync=1, vsync=1, de=0, all strobes 0; timing restarts at (0,0).
- Parameters H_ACTIVE=4, H_FP=1, H_SYNC=1, H_BP=1, V_ACTIVE=2, V_FP=1, V_SYNC=1, V_BP=1, H_POL=1 → hsync=1 only at x=5; period 7 clks; frame 35 clks.
